// File: rtl/clock_time_counter.sv
// Timekeeping core: prescales clk to a 1 Hz tick and keeps 24-hour BCD time (HH:MM:SS),
// with a mode/increment button pair for setting hours and minutes.
module clock_time_counter #(
   parameter int CLK_FREQ = 50_000_000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       mode_btn,
   input  logic       inc_btn,
   output logic [3:0] hr_tens,
   output logic [3:0] hr_ones,
   output logic [3:0] min_tens,
   output logic [3:0] min_ones,
   output logic [3:0] sec_tens,
   output logic [3:0] sec_ones,
   output logic [1:0] mode,
   output logic       sec_tick
);

   localparam int PW = (CLK_FREQ > 2) ? $clog2(CLK_FREQ) : 1;
   localparam logic [PW-1:0] TC = PW'(CLK_FREQ - 1);

   typedef enum logic [1:0] {
      RUN      = 2'b00,
      SET_HOUR = 2'b01,
      SET_MIN  = 2'b10,
      ILLEGAL  = 2'b11
   } mode_t;

   mode_t         state, state_next;
   logic [PW-1:0] presc;
   logic          mode_s, mode_q, inc_s, inc_q;
   logic          mode_ev, inc_ev;
   logic [4:0]    so_n, st_n, mo_n, mt_n;
   logic [7:0]    hr_n;

   // Returns {carry, next digit}; anything at or above the limit wraps to 0.
   function automatic logic [4:0] digit_inc(input logic [3:0] d, input logic [3:0] lim);
      if (d >= lim) return {1'b1, 4'd0};
      return {1'b0, d + 4'd1};
   endfunction

   function automatic logic [7:0] hour_inc(input logic [3:0] t, input logic [3:0] o);
      if (t >= 4'd2 && o >= 4'd3) return 8'h00;
      if (o >= 4'd9)              return {t + 4'd1, 4'd0};
      return {t, o + 4'd1};
   endfunction

   // The extra sampling stage makes button actions land one edge after capture.
   always_ff @(posedge clk) begin
      if (rst) begin
         mode_s <= 1'b0;
         mode_q <= 1'b0;
         inc_s  <= 1'b0;
         inc_q  <= 1'b0;
      end else begin
         mode_s <= mode_btn;
         mode_q <= mode_s;
         inc_s  <= inc_btn;
         inc_q  <= inc_s;
      end
   end

   assign mode_ev = mode_s & ~mode_q;
   assign inc_ev  = inc_s & ~inc_q;

   always_ff @(posedge clk) begin
      if (rst) state <= RUN;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         RUN:      if (mode_ev) state_next = SET_HOUR;
         SET_HOUR: if (mode_ev) state_next = SET_MIN;
         SET_MIN:  if (mode_ev) state_next = RUN;
         default:  state_next = RUN;
      endcase
   end

   assign mode = state;

   always_comb begin
      so_n = digit_inc(sec_ones, 4'd9);
      st_n = digit_inc(sec_tens, 4'd5);
      mo_n = digit_inc(min_ones, 4'd9);
      mt_n = digit_inc(min_tens, 4'd5);
      hr_n = hour_inc(hr_tens, hr_ones);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         presc    <= '0;
         sec_tick <= 1'b0;
         hr_tens  <= 4'd0;
         hr_ones  <= 4'd0;
         min_tens <= 4'd0;
         min_ones <= 4'd0;
         sec_tens <= 4'd0;
         sec_ones <= 4'd0;
      end else begin
         sec_tick <= 1'b0;
         case (state)
            RUN: begin
               // A mode event takes priority over a coincident second tick.
               if (mode_ev) begin
                  presc <= '0;
               end else if (presc == TC) begin
                  presc    <= '0;
                  sec_tick <= 1'b1;
                  sec_ones <= so_n[3:0];
                  if (so_n[4]) begin
                     sec_tens <= st_n[3:0];
                     if (st_n[4]) begin
                        min_ones <= mo_n[3:0];
                        if (mo_n[4]) begin
                           min_tens <= mt_n[3:0];
                           if (mt_n[4]) {hr_tens, hr_ones} <= hr_n;
                        end
                     end
                  end
               end else begin
                  presc <= presc + 1'b1;
               end
            end
            SET_HOUR: begin
               presc <= '0;
               if (mode_ev) begin
                  sec_tens <= 4'd0;
                  sec_ones <= 4'd0;
               end else if (inc_ev) begin
                  {hr_tens, hr_ones} <= hr_n;
               end
            end
            SET_MIN: begin
               presc <= '0;
               if (!mode_ev && inc_ev) begin
                  min_ones <= mo_n[3:0];
                  if (mo_n[4]) min_tens <= mt_n[3:0];
               end
            end
            default: presc <= '0;
         endcase
      end
   end

endmodule

// File: tb/tb_clock_time_counter.sv
// Self-checking bench for clock_time_counter (CLK_FREQ=4): seconds-of-day reference model
// compared every cycle, directed scenarios with literal expectations, then random buttons.
module tb_clock_time_counter;

   logic       clk = 1'b0;
   logic       rst, mode_btn, inc_btn;
   logic [3:0] hr_tens, hr_ones, min_tens, min_ones, sec_tens, sec_ones;
   logic [1:0] mode;
   logic       sec_tick;
   logic [26:0] dut_vec;

   int checks = 0;
   int errors = 0;
   bit chk_en = 1'b0;

   // Reference model: time as seconds of day, buttons as sampled level history.
   int m_t = 0, m_mode = 0, m_presc = 0;
   bit m_tick = 0, m_ms = 0, m_mq = 0, m_is = 0, m_iq = 0;

   clock_time_counter #(.CLK_FREQ(4)) dut (
      .clk(clk), .rst(rst), .mode_btn(mode_btn), .inc_btn(inc_btn),
      .hr_tens(hr_tens), .hr_ones(hr_ones), .min_tens(min_tens), .min_ones(min_ones),
      .sec_tens(sec_tens), .sec_ones(sec_ones), .mode(mode), .sec_tick(sec_tick)
   );

   always #5 clk = ~clk;

   assign dut_vec = {hr_tens, hr_ones, min_tens, min_ones, sec_tens, sec_ones, mode, sec_tick};

   always @(posedge clk) begin
      bit em, ei;
      int h, m;
      em = m_ms & ~m_mq;
      ei = m_is & ~m_iq;
      m_tick = 1'b0;
      if (rst) begin
         m_t = 0; m_mode = 0; m_presc = 0;
         m_ms = 0; m_mq = 0; m_is = 0; m_iq = 0;
      end else begin
         case (m_mode)
            0: begin
               if (em) begin
                  m_mode = 1; m_presc = 0;
               end else if (m_presc == 3) begin
                  m_presc = 0; m_tick = 1'b1; m_t = (m_t + 1) % 86400;
               end else begin
                  m_presc++;
               end
            end
            1: begin
               m_presc = 0;
               if (em) begin
                  m_mode = 2; m_t = (m_t / 60) * 60;
               end else if (ei) begin
                  h = m_t / 3600;
                  m_t = m_t - h * 3600 + ((h + 1) % 24) * 3600;
               end
            end
            default: begin
               m_presc = 0;
               if (em) begin
                  m_mode = 0;
               end else if (ei) begin
                  m = (m_t / 60) % 60;
                  m_t = m_t - m * 60 + ((m + 1) % 60) * 60;
               end
            end
         endcase
         m_mq = m_ms; m_ms = mode_btn;
         m_iq = m_is; m_is = inc_btn;
      end
   end

   function automatic logic [26:0] model_vec();
      int h, m, s;
      h = m_t / 3600;
      m = (m_t / 60) % 60;
      s = m_t % 60;
      return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10),
              2'(m_mode), m_tick};
   endfunction

   task automatic chk(input string name, input logic [26:0] act, input logic [26:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h (hhmmss_mode_tick) at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) chk("model", dut_vec, model_vec());
   end

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic press(input bit m, input bit i);
      mode_btn = m;
      inc_btn  = i;
      @(negedge clk);
      mode_btn = 1'b0;
      inc_btn  = 1'b0;
      @(negedge clk);
   endtask

   task automatic set_time(input int h_incs, input int m_incs);
      press(1, 0);
      repeat (h_incs) press(0, 1);
      press(1, 0);
      repeat (m_incs) press(0, 1);
      press(1, 0);
   endtask

   initial begin
      rst = 1'b1; mode_btn = 1'b1; inc_btn = 1'b1;
      step(2);
      chk("reset", dut_vec, {24'h000000, 2'b00, 1'b0});
      rst = 1'b0; mode_btn = 1'b0; inc_btn = 1'b0;
      chk_en = 1'b1;

      step(4);
      chk("first_tick", dut_vec, {24'h000001, 2'b00, 1'b1});
      step(236);
      chk("one_minute", dut_vec, {24'h000100, 2'b00, 1'b1});

      rst = 1'b1; step(1); rst = 1'b0;
      step(148);
      chk("at_37s", dut_vec, {24'h000037, 2'b00, 1'b1});
      press(1, 0);
      chk("enter_set_hour", dut_vec, {24'h000037, 2'b01, 1'b0});
      repeat (25) press(0, 1);
      chk("hour_inc_25", dut_vec, {24'h010037, 2'b01, 1'b0});
      press(1, 0);
      chk("enter_set_min", dut_vec, {24'h010000, 2'b10, 1'b0});
      repeat (61) press(0, 1);
      chk("min_inc_61", dut_vec, {24'h010100, 2'b10, 1'b0});
      press(1, 0);
      chk("back_to_run", dut_vec, {24'h010100, 2'b00, 1'b0});
      step(3);
      chk("no_tick_yet", dut_vec, {24'h010100, 2'b00, 1'b0});
      step(1);
      chk("full_first_second", dut_vec, {24'h010101, 2'b00, 1'b1});

      set_time(22, 58);
      chk("set_2359", dut_vec, {24'h235900, 2'b00, 1'b0});
      step(236);
      chk("at_235959", dut_vec, {24'h235959, 2'b00, 1'b1});
      step(4);
      chk("day_wrap", dut_vec, {24'h000000, 2'b00, 1'b1});

      set_time(9, 59);
      step(236);
      chk("at_095959", dut_vec, {24'h095959, 2'b00, 1'b1});
      step(4);
      chk("wrap_to_10", dut_vec, {24'h100000, 2'b00, 1'b1});

      set_time(9, 59);
      step(240);
      chk("wrap_to_20", dut_vec, {24'h200000, 2'b00, 1'b1});

      press(1, 0);
      inc_btn = 1'b1; step(20); inc_btn = 1'b0; step(2);
      chk("held_inc_once", dut_vec, {24'h210000, 2'b01, 1'b0});
      press(1, 1);
      chk("mode_beats_inc", dut_vec, {24'h210000, 2'b10, 1'b0});
      press(1, 0);
      press(0, 1);
      chk("inc_ignored_run", dut_vec, {24'h210000, 2'b00, 1'b0});

      press(1, 0);
      repeat (17) press(0, 1);
      press(1, 0);
      repeat (27) press(0, 1);
      chk("set_1427", dut_vec, {24'h142700, 2'b10, 1'b0});
      rst = 1'b1; step(1);
      chk("reset_mid_set", dut_vec, {24'h000000, 2'b00, 1'b0});
      rst = 1'b0; step(3);
      chk("resume_wait", dut_vec, {24'h000000, 2'b00, 1'b0});
      step(1);
      chk("resume_tick", dut_vec, {24'h000001, 2'b00, 1'b1});

      repeat (3000) begin
         @(negedge clk);
         mode_btn = ($urandom_range(0, 15) == 0);
         inc_btn  = ($urandom_range(0, 3) == 0);
         rst      = ($urandom_range(0, 499) == 0);
      end
      mode_btn = 1'b0; inc_btn = 1'b0; rst = 1'b0;
      step(4);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/clock_time_counter.md
# clock_time_counter

Timekeeping core of the digital clock. It divides the system clock down to a 1 Hz tick and keeps 24-hour time as six BCD digits (HH:MM:SS). Each digit drives one downstream BCD-to-seven-segment decoder directly. A two-button interface lets the user set hours and minutes.

## Interface

Parameters:
- CLK_FREQ, 50_000_000: system clock cycles per second; the prescaler terminal count is CLK_FREQ-1. Minimum value is 2.

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- rst  input  1  reset, synchronous, active-high.
- mode_btn  input  1  mode-advance button. Level input, already debounced and synchronized to clk.
- inc_btn  input  1  increment button. Level input, already debounced and synchronized to clk.
- hr_tens  output  4  hours tens digit, BCD, range 0–2.
- hr_ones  output  4  hours ones digit, BCD, range 0–9.
- min_tens  output  4  minutes tens digit, BCD, range 0–5.
- min_ones  output  4  minutes ones digit, BCD, range 0–9.
- sec_tens  output  4  seconds tens digit, BCD, range 0–5.
- sec_ones  output  4  seconds ones digit, BCD, range 0–9.
- mode  output  2  current mode: 2'b00 RUN, 2'b01 SET_HOUR, 2'b10 SET_MIN.
- sec_tick  output  1  one-cycle pulse when seconds advance in RUN.

## Operation

- Rising-edge detection on both buttons:
  - Registered previous level; edge = btn & ~btn_q.
  - Held buttons produce exactly one event.
- Mode FSM:
  - mode_btn event advances RUN → SET_HOUR → SET_MIN → RUN.
  - Encoding 2'b11 is unreachable. If reached, the next cycle goes to RUN.
- RUN:
  - Prescaler counts 0..CLK_FREQ-1 and wraps.
  - At terminal count, seconds increment.
  - Carry chain:
    - sec_ones 9→0 carries to sec_tens.
    - sec_tens 5→0 carries to min_ones.
    - min_ones 9→0 carries to min_tens.
    - min_tens 5→0 carries to hours.
  - Hours step as a pair: 09→10, 19→20, 23→00 (day wrap).
  - inc_btn events are ignored in RUN.
- SET_HOUR:
  - Time is frozen and the prescaler is held at 0.
  - An inc event adds one hour, 23→00, with no effect on minutes or seconds.
- SET_MIN:
  - Time is frozen and the prescaler is held at 0.
  - An inc event adds one minute, 59→00, with no carry into hours.
  - Entering SET_MIN clears sec_tens/sec_ones to 0.
- Leaving SET_MIN → RUN: prescaler starts at 0, so the first second after setting is a full CLK_FREQ cycles.
- Simultaneous mode and inc events in the same cycle: the mode change wins and the inc is discarded.
- All digit registers hold legal BCD at all times. No value ≥ 10, and no hour > 23, is ever produced.

## Timing

- Reset values (takes effect on the first clk edge with rst=1):
  - All six digits = 0.
  - mode = 2'b00, sec_tick = 0.
  - Prescaler and button edge registers = 0.
- rst overrides all other inputs, including mid-carry and mid-setting. There is no partial update.
- Digit, mode and sec_tick outputs are registered; none are driven combinationally from inputs.
- Tick latency:
  - The prescaler reaches CLK_FREQ-1 at edge N.
  - At edge N+1, the prescaler returns to 0, the digits show the incremented time, and sec_tick=1 for that single cycle.
  - The full carry ripple (e.g. 23:59:59→00:00:00) completes on that same edge.
- Button latency:
  - A button rises before edge N and is captured at edge N.
  - The mode change or digit increment is visible after edge N+1.
- sec_tick stays 0 in SET modes.

## Test plan

Run with CLK_FREQ=4.

- Reset: drive rst=1 for 2 cycles with buttons high → all digits 0, mode=00, sec_tick=0. Releasing buttons produces no event.
- Basic count: run 4 cycles → sec_ones=1 and sec_tick pulses once. After 240 cycles → 00:01:00.
- Day wrap:
  - Set 23:59 via buttons and let seconds reach 59.
  - On the next tick, all digits become 0 on one edge and sec_tick=1.
  - Also check 09:59:59→10:00:00 and 19:59:59→20:00:00.
- Setting:
  - From 00:00:37, press mode once and inc 25 times → hours 01, minutes 00, seconds 37.
  - Press mode → seconds read 00. Press inc 61 times → minutes 01, hours still 01.
  - Press mode → RUN; the first sec_tick arrives exactly 4 cycles after mode shows 00.
- Button edge rules:
  - Hold inc high 20 cycles in SET_HOUR → exactly one increment.
  - Assert mode and inc rising together in SET_HOUR → mode=10, hours unchanged.
  - Press inc in RUN → no change.
- Reset mid-operation: assert rst in SET_MIN at 14:27 → 00:00:00, mode=00. Counting resumes 4 cycles after rst drops.
